// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline hazard/control unit.
//   stall_cause_t : which stall source won in a given cycle
//   md_state_t    : mult/div sequencer states
//   fetch_state_t : fetch-redirect discard states
//   DEF_*         : default pipeline geometry and mult/div latencies
//   PERF_*        : perf_cnt slot assigned to each stall cause
//   cnt_width()   : width of the mult/div down-counter
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int DEF_NSTAGE      = 5;
    localparam int DEF_EX_STAGE    = 2;
    localparam int DEF_MEM_STAGE   = 3;
    localparam int DEF_MULT_CYCLES = 4;
    localparam int DEF_DIV_CYCLES  = 32;

    localparam int PERF_DWAIT   = 0;
    localparam int PERF_MDWAIT  = 1;
    localparam int PERF_LOADUSE = 2;
    localparam int PERF_IWAIT   = 3;

    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_IWAIT,
        CAUSE_LOADUSE,
        CAUSE_MDWAIT,
        CAUSE_DWAIT
    } stall_cause_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

    typedef enum logic {
        F_IDLE,
        F_DISCARD
    } fetch_state_t;

    // The counter is loaded with (cycles - 1), so it must hold max-1.
    // Never narrower than one bit so the single-cycle case still builds.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_md_seq.sv
// ---------------------------------------------------------------------------
// md_seq
// Multi-cycle mult/div busy sequencer (IDLE -> BUSY -> DONE -> IDLE).
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   md_start    : mult/div enters the EX stage this cycle
//   md_is_div   : qualifies md_start, 1 = divide
//   abort       : exception/eret kill; drops BUSY/DONE without a done pulse
//   md_busy     : high for every BUSY cycle
//   md_done     : one-cycle pulse in DONE
// ---------------------------------------------------------------------------
module md_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_is_div,
    input  logic abort,
    output logic md_busy,
    output logic md_done
);

    localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // BUSY lasts exactly (load + 1) cycles: the cnt==0 cycle is still busy.
    // A start arriving in DONE chains straight into the next operation.
    // Abort has the last word so a killed instruction never reports done,
    // including one that tries to start in the same cycle as the kill.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        md_busy = 1'b0;
        md_done = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    state_d = MD_BUSY;
                    cnt_d   = md_is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            MD_BUSY: begin
                md_busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = MD_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MD_DONE: begin
                md_done = 1'b1;
                if (md_start) begin
                    state_d = MD_BUSY;
                    cnt_d   = md_is_div ? DIV_LOAD : MULT_LOAD;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
        if (abort) begin
            state_d = MD_IDLE;
            md_done = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Hazard/control unit for an NSTAGE-deep in-order pipeline. Picks the
// deepest stalling stage K, holds stages 0..K, bubbles stage K+1, applies
// redirect/exception flushes, sequences mult/div latency and drops the
// stale instruction of a fetch that was in flight during a redirect.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   i_pending, i_data_ok     : instruction fetch status
//   d_pending, d_data_ok     : memory-stage data status
//   load_use                 : decode waits on a load result
//   md_start, md_is_div      : mult/div issue into EX_STAGE
//   redirect, redirect_exc   : PC redirect; exc kills all younger stages
//   stall[NSTAGE], flush[NSTAGE] : per-stage hold / bubble insert
//   md_busy, md_done         : mult/div sequencer status
//   perf_cnt[4]              : stall-cause cycle counters
//                              (d wait, md wait, load_use, i wait)
// Build option:
//   PIPE_CTRL_PERF_EN defined   -> 32-bit wrapping counters in perf_cnt
//   PIPE_CTRL_PERF_EN undefined -> perf_cnt is constant 0, no counter flops
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE      = DEF_NSTAGE,
    parameter int EX_STAGE    = DEF_EX_STAGE,
    parameter int MEM_STAGE   = DEF_MEM_STAGE,
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_pending,
    input  logic                  i_data_ok,
    input  logic                  d_pending,
    input  logic                  d_data_ok,
    input  logic                  load_use,
    input  logic                  md_start,
    input  logic                  md_is_div,
    input  logic                  redirect,
    input  logic                  redirect_exc,
    output logic [NSTAGE-1:0]     stall,
    output logic [NSTAGE-1:0]     flush,
    output logic                  md_busy,
    output logic                  md_done,
    output logic [3:0][31:0]      perf_cnt
);

    fetch_state_t fetch_q, fetch_d;
    logic         d_wait;
    logic         md_wait;
    logic         i_wait;
    logic         discard_drop;
    int           stall_k;

    md_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_seq (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .abort     (redirect_exc),
        .md_busy   (md_busy),
        .md_done   (md_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_q <= F_IDLE;
        end else begin
            fetch_q <= fetch_d;
        end
    end

    // A redirect that catches a fetch still in flight must throw away the
    // returning word. A return coincident with the redirect needs no
    // DISCARD because the ordinary redirect flush already kills it.
    always_comb begin
        fetch_d = fetch_q;
        case (fetch_q)
            F_IDLE: begin
                if (redirect && i_pending && !i_data_ok) begin
                    fetch_d = F_DISCARD;
                end
            end
            F_DISCARD: begin
                if (i_data_ok) begin
                    fetch_d = F_IDLE;
                end
            end
            default: fetch_d = F_IDLE;
        endcase
    end

    assign d_wait       = d_pending && !d_data_ok;
    assign md_wait      = md_busy;
    assign i_wait       = (i_pending && !i_data_ok) || (fetch_q == F_DISCARD);
    assign discard_drop = (fetch_q == F_DISCARD) && i_data_ok;

    // stall_k is the deepest stalling stage, -1 when nothing stalls.
    always_comb begin
        stall_k = -1;
        if (i_wait) begin
            stall_k = 0;
        end
        if (load_use && stall_k <= 1) begin
            stall_k = 1;
        end
        if (md_wait && stall_k <= EX_STAGE) begin
            stall_k = EX_STAGE;
        end
        if (d_wait && stall_k <= MEM_STAGE) begin
            stall_k = MEM_STAGE;
        end
    end

    // Stall/flush conflicts: an exception kill beats a hold; otherwise a
    // held stage must keep its instruction, so its flush is dropped.
    // Outputs are forced quiet while reset is asserted.
    always_comb begin
        stall = '0;
        flush = '0;
        for (int j = 0; j < NSTAGE; j++) begin
            stall[j] = (j <= stall_k);
            flush[j] = ((stall_k >= 0) && (j == stall_k + 1))
                    || ((j == 1) && ((redirect && (stall_k < 0)) || discard_drop))
                    || (redirect_exc && (j >= 1) && (j <= NSTAGE - 2));
        end
        if (redirect_exc) begin
            stall = stall & ~flush;
        end else begin
            flush = flush & ~stall;
        end
        if (reset) begin
            stall = '0;
            flush = '0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    stall_cause_t       win_cause;
    logic [3:0][31:0]   perf_q, perf_d;

    // The winning cause is the source that set stall_k; on a depth tie the
    // deeper-in-the-pipe source is charged.
    always_comb begin
        win_cause = CAUSE_NONE;
        if (d_wait && stall_k == MEM_STAGE) begin
            win_cause = CAUSE_DWAIT;
        end else if (md_wait && stall_k == EX_STAGE) begin
            win_cause = CAUSE_MDWAIT;
        end else if (load_use && stall_k == 1) begin
            win_cause = CAUSE_LOADUSE;
        end else if (i_wait) begin
            win_cause = CAUSE_IWAIT;
        end
    end

    always_comb begin
        perf_d = perf_q;
        case (win_cause)
            CAUSE_DWAIT:   perf_d[PERF_DWAIT]   = perf_q[PERF_DWAIT]   + 32'd1;
            CAUSE_MDWAIT:  perf_d[PERF_MDWAIT]  = perf_q[PERF_MDWAIT]  + 32'd1;
            CAUSE_LOADUSE: perf_d[PERF_LOADUSE] = perf_q[PERF_LOADUSE] + 32'd1;
            CAUSE_IWAIT:   perf_d[PERF_IWAIT]   = perf_q[PERF_IWAIT]   + 32'd1;
            default:       perf_d = perf_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cnt = perf_q;
`else
    assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl with default geometry (5 stages, EX=2,
// MEM=3, mult 4 / div 32 cycles). Expected values come from constant
// vectors, hand-written sequences and a cycle-level reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_ctrl;

    localparam int NS   = 5;
    localparam int EXS  = 2;
    localparam int MEMS = 3;
    localparam int MULC = 4;
    localparam int DIVC = 32;

    typedef struct packed {
        logic i_pending;
        logic i_data_ok;
        logic d_pending;
        logic d_data_ok;
        logic load_use;
        logic md_start;
        logic md_is_div;
        logic redirect;
        logic redirect_exc;
    } in_t;

    typedef struct {
        in_t         stim;
        logic [4:0]  exp_stall;
        logic [4:0]  exp_flush;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic i_pending, i_data_ok, d_pending, d_data_ok, load_use;
    logic md_start, md_is_div, redirect, redirect_exc;
    logic [NS-1:0]    stall, flush;
    logic             md_busy, md_done;
    logic [3:0][31:0] perf_cnt;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[15];

    // Reference model state: remaining busy cycles, pending done pulse,
    // discard flag and per-cause stall counts.
    int          md_left   = 0;
    bit          md_done_m = 1'b0;
    bit          disc_m    = 1'b0;
    logic [31:0] perf_m [4];

    pipe_ctrl #(
        .NSTAGE      (NS),
        .EX_STAGE    (EXS),
        .MEM_STAGE   (MEMS),
        .MULT_CYCLES (MULC),
        .DIV_CYCLES  (DIVC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_pending    (i_pending),
        .i_data_ok    (i_data_ok),
        .d_pending    (d_pending),
        .d_data_ok    (d_data_ok),
        .load_use     (load_use),
        .md_start     (md_start),
        .md_is_div    (md_is_div),
        .redirect     (redirect),
        .redirect_exc (redirect_exc),
        .stall        (stall),
        .flush        (flush),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .perf_cnt     (perf_cnt)
    );

    always #5 clk = ~clk;

    // Deepest active stall source in the current cycle, -1 if none.
    function automatic int winning_k();
        int k;
        k = -1;
        if ((i_pending && !i_data_ok) || disc_m) k = 0;
        if (load_use && k < 1) k = 1;
        if (md_left > 0 && k < EXS) k = EXS;
        if (d_pending && !d_data_ok && k < MEMS) k = MEMS;
        return k;
    endfunction

    // perf slot charged this cycle, -1 if none.
    function automatic int winning_idx();
        int k;
        k = winning_k();
        if (k < 0) return -1;
        if (d_pending && !d_data_ok && k == MEMS) return 0;
        if (md_left > 0 && k == EXS) return 1;
        if (load_use && k == 1) return 2;
        return 3;
    endfunction

    // Model advances on the same edges as the DUT.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            md_left   <= 0;
            md_done_m <= 1'b0;
            disc_m    <= 1'b0;
            for (int i = 0; i < 4; i++) perf_m[i] <= 32'd0;
        end else begin
            if (winning_idx() >= 0) perf_m[winning_idx()] <= perf_m[winning_idx()] + 32'd1;
            if (redirect_exc) begin
                md_left   <= 0;
                md_done_m <= 1'b0;
            end else if (md_left > 0) begin
                md_left   <= md_left - 1;
                md_done_m <= (md_left == 1);
            end else begin
                md_done_m <= 1'b0;
                if (md_start) md_left <= md_is_div ? DIVC : MULC;
            end
            disc_m <= disc_m ? !i_data_ok : (redirect && i_pending && !i_data_ok);
        end
    end

    task automatic checkValue(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the reference model.
    task automatic checkOutput();
        logic [NS-1:0]    es, ef, exc_mask;
        logic [3:0][31:0] ep;
        int               k;
        k  = winning_k();
        es = '0;
        ef = '0;
        exc_mask = NS'(((64'd1 << (NS - 1)) - 64'd1) & ~64'd1);
        if (k >= 0) begin
            es = NS'((64'd1 << (k + 1)) - 64'd1);
            ef = NS'(64'd1 << (k + 1));
        end
        if (redirect && k < 0) ef = ef | NS'(2);
        if (disc_m && i_data_ok) ef = ef | NS'(2);
        if (redirect_exc) begin
            ef = ef | exc_mask;
            es = es & ~ef;
        end else begin
            ef = ef & ~es;
        end
        if (reset) begin
            es = '0;
            ef = '0;
        end
`ifdef PIPE_CTRL_PERF_EN
        for (int i = 0; i < 4; i++) ep[i] = perf_m[i];
`else
        ep = '0;
`endif
        checkValue("model_stall", stall, es);
        checkValue("model_flush", flush, ef);
        checkValue("model_md_busy", md_busy, (md_left > 0));
        checkValue("model_md_done", md_done, (md_done_m && !redirect_exc && !reset));
        checkValue("model_perf", perf_cnt, ep);
    endtask

    // Drive one cycle of inputs at the falling edge and check outputs.
    task automatic applyStimulus(input in_t v);
        @(negedge clk);
        i_pending    = v.i_pending;
        i_data_ok    = v.i_data_ok;
        d_pending    = v.d_pending;
        d_data_ok    = v.d_data_ok;
        load_use     = v.load_use;
        md_start     = v.md_start;
        md_is_div    = v.md_is_div;
        redirect     = v.redirect;
        redirect_exc = v.redirect_exc;
        #1;
        checkOutput();
    endtask

    function automatic in_t mk(input logic ip, input logic iok, input logic dp, input logic dok,
                               input logic lu, input logic red, input logic exc);
        in_t v;
        v = '0;
        v.i_pending    = ip;
        v.i_data_ok    = iok;
        v.d_pending    = dp;
        v.d_data_ok    = dok;
        v.load_use     = lu;
        v.redirect     = red;
        v.redirect_exc = exc;
        return v;
    endfunction

    function automatic in_t mkmd(input logic is_div);
        in_t v;
        v = '0;
        v.md_start  = 1'b1;
        v.md_is_div = is_div;
        return v;
    endfunction

    // Assert reset mid-cycle, check that it acts immediately, then release.
    task automatic pulseReset(input string tag);
        #2 reset = 1'b1;
        #1;
        checkValue({tag, "_rst_stall"}, stall, 0);
        checkValue({tag, "_rst_flush"}, flush, 0);
        checkValue({tag, "_rst_busy"}, md_busy, 0);
        checkValue({tag, "_rst_done"}, md_done, 0);
        checkValue({tag, "_rst_perf"}, perf_cnt, 0);
        @(negedge clk);
        i_pending = 0; i_data_ok = 0; d_pending = 0; d_data_ok = 0; load_use = 0;
        md_start = 0; md_is_div = 0; redirect = 0; redirect_exc = 0;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        in_t idle;
        in_t r;
        int  n;
        idle = '0;

        vecs[0]  = '{mk(0,0,0,0,0,0,0), 5'b00000, 5'b00000, "idle"};
        vecs[1]  = '{mk(0,0,1,0,0,0,0), 5'b01111, 5'b10000, "dwait"};
        vecs[2]  = '{mk(0,0,1,1,0,0,0), 5'b00000, 5'b00000, "dreturn"};
        vecs[3]  = '{mk(0,0,0,0,1,0,0), 5'b00011, 5'b00100, "loaduse"};
        vecs[4]  = '{mk(0,0,1,0,1,0,0), 5'b01111, 5'b10000, "lu_dwait"};
        vecs[5]  = '{mk(1,0,0,0,0,0,0), 5'b00001, 5'b00010, "iwait"};
        vecs[6]  = '{mk(1,1,0,0,0,0,0), 5'b00000, 5'b00000, "ireturn"};
        vecs[7]  = '{mk(0,0,0,0,0,1,0), 5'b00000, 5'b00010, "redirect"};
        vecs[8]  = '{mk(1,1,0,0,0,1,0), 5'b00000, 5'b00010, "redir_iok"};
        vecs[9]  = '{mk(0,0,0,0,0,0,0), 5'b00000, 5'b00000, "no_discard"};
        vecs[10] = '{mk(0,0,0,0,1,1,0), 5'b00011, 5'b00100, "redir_lu"};
        vecs[11] = '{mk(0,0,0,0,0,1,1), 5'b00000, 5'b01110, "exc"};
        vecs[12] = '{mk(0,0,1,0,0,1,1), 5'b00001, 5'b11110, "exc_dwait"};
        vecs[13] = '{mk(0,0,0,0,1,1,1), 5'b00001, 5'b01110, "exc_lu"};
        vecs[14] = '{mk(1,0,0,0,1,0,0), 5'b00011, 5'b00100, "iwait_lu"};

        // Reset with active inputs: outputs must stay quiet.
        reset = 1'b1;
        i_pending = 0; i_data_ok = 0; d_pending = 1; d_data_ok = 0; load_use = 1;
        md_start = 1; md_is_div = 0; redirect = 0; redirect_exc = 0;
        repeat (2) @(negedge clk);
        #1;
        checkValue("reset_stall", stall, 0);
        checkValue("reset_flush", flush, 0);
        checkValue("reset_busy", md_busy, 0);
        checkValue("reset_done", md_done, 0);
        checkValue("reset_perf", perf_cnt, 0);
        @(negedge clk);
        d_pending = 0; load_use = 0; md_start = 0;
        reset = 1'b0;

        $display("[TB] combinational vectors");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].stim);
            checkValue({vecs[i].name, "_stall"}, stall, vecs[i].exp_stall);
            checkValue({vecs[i].name, "_flush"}, flush, vecs[i].exp_flush);
        end

        $display("[TB] d wait sequence");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(0,0,1,0,0,0,0));
            checkValue("dseq_stall", stall, 5'b01111);
            checkValue("dseq_flush", flush, 5'b10000);
        end
        applyStimulus(mk(0,0,1,1,0,0,0));
        checkValue("dseq_ret_stall", stall, 5'b00000);

        $display("[TB] multiply sequence");
        applyStimulus(mkmd(1'b0));
        checkValue("mul_start_busy", md_busy, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(idle);
            checkValue("mul_busy", md_busy, 1);
            checkValue("mul_stall", stall, 5'b00111);
            checkValue("mul_flush", flush, 5'b01000);
        end
        applyStimulus(idle);
        checkValue("mul_done", md_done, 1);
        checkValue("mul_done_busy", md_busy, 0);
        applyStimulus(idle);
        checkValue("mul_done_once", md_done, 0);

        $display("[TB] back-to-back multiply from DONE");
        applyStimulus(mkmd(1'b0));
        repeat (3) applyStimulus(idle);
        applyStimulus(mkmd(1'b0));
        checkValue("b2b_first_busy", md_busy, 1);
        applyStimulus(mkmd(1'b0));
        checkValue("b2b_done", md_done, 1);
        applyStimulus(idle);
        checkValue("b2b_rebusy", md_busy, 1);
        repeat (5) applyStimulus(idle);
        checkValue("b2b_settled", md_busy, 0);

        $display("[TB] divide sequence");
        applyStimulus(mkmd(1'b1));
        n = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(idle);
            if (!md_busy) break;
            n++;
        end
        checkValue("div_busy_cycles", n, 32);
        checkValue("div_done", md_done, 1);

        $display("[TB] exception during divide");
        applyStimulus(mkmd(1'b1));
        repeat (21) applyStimulus(idle);
        applyStimulus(mk(0,0,0,0,0,1,1));
        checkValue("exc_md_busy", md_busy, 1);
        checkValue("exc_md_flush", flush, 5'b01110);
        checkValue("exc_md_stall", stall, 5'b00001);
        applyStimulus(idle);
        checkValue("exc_md_abort", md_busy, 0);
        checkValue("exc_md_nodone", md_done, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(idle);
            checkValue("exc_md_nodone_later", md_done, 0);
        end

        $display("[TB] fetch discard sequence");
        applyStimulus(mk(1,0,0,0,0,1,0));
        checkValue("disc_redir_stall", stall, 5'b00001);
        checkValue("disc_redir_flush", flush, 5'b00010);
        applyStimulus(mk(0,0,0,0,0,0,0));
        checkValue("disc_hold_stall", stall, 5'b00001);
        applyStimulus(mk(0,0,0,0,0,1,0));
        checkValue("disc_redir_again", stall, 5'b00001);
        applyStimulus(mk(0,1,0,0,0,0,0));
        checkValue("disc_drop_stall", stall, 5'b00001);
        checkValue("disc_drop_flush", flush, 5'b00010);
        applyStimulus(idle);
        checkValue("disc_exit_stall", stall, 5'b00000);
        checkValue("disc_exit_flush", flush, 5'b00000);

`ifdef PIPE_CTRL_PERF_EN
        $display("[TB] perf counters");
        pulseReset("perf_pre");
        repeat (5) applyStimulus(mk(0,0,1,0,0,0,0));
        repeat (3) applyStimulus(mk(0,0,0,0,1,0,0));
        applyStimulus(idle);
        checkValue("perf_dwait", perf_cnt[0], 5);
        checkValue("perf_mdwait", perf_cnt[1], 0);
        checkValue("perf_loaduse", perf_cnt[2], 3);
        checkValue("perf_iwait", perf_cnt[3], 0);
`endif

        $display("[TB] reset mid-run");
        r = mkmd(1'b1);
        r.redirect  = 1'b1;
        r.i_pending = 1'b1;
        applyStimulus(r);
        repeat (2) applyStimulus(mk(0,0,1,0,0,0,0));
        pulseReset("midrun");
        applyStimulus(idle);
        checkValue("midrun_after_stall", stall, 0);
        checkValue("midrun_after_busy", md_busy, 0);

        $display("[TB] random stimulus");
        for (int i = 0; i < 1500; i++) begin
            r = '0;
            r.i_pending    = ($urandom_range(0, 3) != 0);
            r.i_data_ok    = ($urandom_range(0, 2) == 0);
            r.d_pending    = ($urandom_range(0, 2) == 0);
            r.d_data_ok    = ($urandom_range(0, 1) == 0);
            r.load_use     = ($urandom_range(0, 4) == 0);
            r.md_start     = ($urandom_range(0, 5) == 0);
            r.md_is_div    = ($urandom_range(0, 3) == 0);
            r.redirect     = ($urandom_range(0, 7) == 0);
            r.redirect_exc = ($urandom_range(0, 24) == 0);
            applyStimulus(r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
